// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the 4-digit display driver.
// Optional BIN2BCD_SAT_EN: out-of-range values saturate to 9999 instead of showing EEEE.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [BIN_W-1:0] bin_in,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [3:0]       digits [DIGITS]
);

   // state   | meaning
   // S_IDLE  | waiting for start; results held
   // S_SHIFT | one add-3/shift step per cycle, BIN_W cycles
   // S_DONE  | results visible, done pulses, back to idle
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // One spare digit so a full 16-bit input (65535) never loses carries.
   localparam int SW    = 4*DIGITS + 4;
   localparam int NDIG  = SW/4;
   localparam int CNT_W = $clog2(BIN_W+1);
   localparam int OW    = 4*DIGITS;

`ifdef BIN2BCD_SAT_EN
   localparam logic [OW-1:0] OVF_PAT = {DIGITS{4'h9}};
`else
   localparam logic [OW-1:0] OVF_PAT = {DIGITS{4'hE}};
`endif

   state_t              state_q, state_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [SW-1:0]       scr_q, scr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_pend_q, ovf_pend_d;
   logic [OW-1:0]       dig_q, dig_d;
   logic                ovf_q, ovf_d;

   logic [SW-1:0]       scr_adj;
   logic [SW-1:0]       scr_shifted;
   logic                in_ovf;

   generate
      if (BIN_W >= 14) begin : g_ovf_cmp
         assign in_ovf = (32'(bin_in) > 32'd9999);
      end else begin : g_no_ovf
         assign in_ovf = 1'b0;
      end
   endgenerate

   always_comb begin
      scr_adj = scr_q;
      for (int i = 0; i < NDIG; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) begin
            scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
         end
      end
      scr_shifted = {scr_adj[SW-2:0], bin_q[BIN_W-1]};
   end

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      scr_d      = scr_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      dig_d      = dig_q;
      ovf_d      = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bin_d      = bin_in;
               scr_d      = '0;
               ovf_pend_d = in_ovf;
               cnt_d      = CNT_W'(BIN_W);
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            scr_d = scr_shifted;
            bin_d = bin_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
               // Results land together with the transition so they are visible during S_DONE.
               if (ovf_pend_q) begin
                  dig_d = OVF_PAT;
                  ovf_d = 1'b1;
               end else begin
                  dig_d = scr_shifted[OW-1:0];
                  ovf_d = 1'b0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         bin_q      <= '0;
         scr_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         dig_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         scr_q      <= scr_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         dig_q      <= dig_d;
         ovf_q      <= ovf_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign ovf  = ovf_q;

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_dig
         assign digits[g] = dig_q[4*g +: 4];
      end
   endgenerate

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: arithmetic reference model checked every cycle plus literal spot checks.
module tb_bin_to_bcd_seq;

   localparam int BIN_W = 14;

`ifdef BIN2BCD_SAT_EN
   localparam logic [15:0] OVF_PAT = 16'h9999;
`else
   localparam logic [15:0] OVF_PAT = 16'hEEEE;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [BIN_W-1:0] bin_in = '0;
   logic             start = 1'b0;
   logic             busy, done, ovf;
   logic [3:0]       digits [4];
   logic [15:0]      dut_dig;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   logic chk_en = 1'b0;

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4)) dut (
      .clk(clk), .reset_n(reset_n), .bin_in(bin_in), .start(start),
      .busy(busy), .done(done), .ovf(ovf), .digits(digits)
   );

   always #5 clk = ~clk;

   assign dut_dig = {digits[3], digits[2], digits[1], digits[0]};

   function automatic logic [15:0] exp_dig(input int v);
      if (v > 9999) return OVF_PAT;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a conversion occupies BIN_W+1 busy cycles; results appear on the last.
   int               m_cnt;
   int               m_val;
   logic [15:0]      m_dig;
   logic             m_ovf;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt <= 0;
         m_val <= 0;
         m_dig <= '0;
         m_ovf <= 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2) begin
            m_dig <= exp_dig(m_val);
            m_ovf <= (m_val > 9999);
         end
      end else if (start) begin
         m_val <= int'(bin_in);
         m_cnt <= BIN_W + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",   {15'd0, busy}, {15'd0, m_cnt > 0});
         check("done",   {15'd0, done}, {15'd0, m_cnt == 1});
         check("ovf",    {15'd0, ovf},  {15'd0, m_ovf});
         check("digits", dut_dig,       m_dig);
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic run_conv(input int v, input logic [15:0] exp_d, input logic exp_o);
      int lat;
      lat = 0;
      @(posedge clk); #2;
      start  = 1'b1;
      bin_in = BIN_W'(v);
      @(posedge clk); #2;
      start  = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout: no done for input %0d", v);
      end else begin
         check("latency", 16'(lat), 16'(BIN_W + 1));
         check("lit_digits", dut_dig, exp_d);
         check("lit_ovf", {15'd0, ovf}, {15'd0, exp_o});
      end
      @(posedge clk); #2;
   endtask

   initial begin
      int d0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_digits", dut_dig, 16'h0000);
      #1;
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // 1-3: basic, boundaries, overflow
      run_conv(1234,  16'h1234, 1'b0);
      run_conv(0,     16'h0000, 1'b0);
      run_conv(9999,  16'h9999, 1'b0);
      run_conv(10000, OVF_PAT,  1'b1);
      run_conv(16383, OVF_PAT,  1'b1);
      run_conv(7,     16'h0007, 1'b0);

      // 4: starts while busy are ignored
      d0 = done_cnt;
      @(posedge clk); #2;
      start = 1'b1; bin_in = BIN_W'(42);
      @(posedge clk); #2;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      start = 1'b1; bin_in = BIN_W'(7777);
      @(posedge clk); #2;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("busy_ign_pulses", 16'(done_cnt - d0), 16'd1);
      check("busy_ign_digits", dut_dig, 16'h0042);
      check("busy_ign_idle", {15'd0, busy}, 16'd0);
      run_conv(7777, 16'h7777, 1'b0);

      // 5: reset mid-SHIFT discards the conversion
      run_conv(5678, 16'h5678, 1'b0);
      @(posedge clk); #2;
      start = 1'b1; bin_in = BIN_W'(321);
      @(posedge clk); #2;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_busy", {15'd0, busy}, 16'd0);
      check("midrst_done", {15'd0, done}, 16'd0);
      check("midrst_ovf", {15'd0, ovf}, 16'd0);
      check("midrst_digits", dut_dig, 16'h0000);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      run_conv(321, 16'h0321, 1'b0);

      // 6: start held high, incrementing input across the overflow boundary
      d0 = done_cnt;
      @(posedge clk); #2;
      start = 1'b1; bin_in = BIN_W'(9990);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #2;
         bin_in = bin_in + 1'b1;
      end
      start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      check("b2b_pulses", 16'(done_cnt - d0), 16'd7);
      check("b2b_last_ovf", {15'd0, ovf}, 16'd1);

      @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
